// File: rtl/eth_wb_mem_pkg.sv
// eth_wb_mem_pkg: shared FSM states, widths and the address decode for the Wishbone slave memory.
package eth_wb_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int WAIT_W = 4;
    localparam int STAT_W = 16;
    function automatic logic decode_ok(input logic [31:0] adr, input logic [3:0] sel,
                                       input logic [31:0] base, input logic [31:0] bytes);
        return adr >= base && (adr - base) < bytes && adr[1:0] == 2'b00 && sel != 4'b0000;
    endfunction
endpackage

// File: rtl/eth_wb_mem_ram.sv
// eth_wb_mem_ram: single-port word RAM with byte write enables and registered read.
module eth_wb_mem_ram #(
    parameter int WORDS = 1024,
    parameter int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/eth_wb_slave_mem.sv
// eth_wb_slave_mem: Wishbone B3 classic slave memory with programmable wait states and error decode.
// Define ETH_WB_SLAVE_MEM_STATS_EN to add saturating read/write/error access counters.
module eth_wb_slave_mem
    import eth_wb_mem_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [3:0]  RST_WAIT  = 4'd1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic        cfg_wait_we_i,
    input  logic [3:0]  cfg_wait_i,
`ifdef ETH_WB_SLAVE_MEM_STATS_EN
    output logic [15:0] rd_cnt_o,
    output logic [15:0] wr_cnt_o,
    output logic [15:0] err_cnt_o,
`endif
    output logic        busy_o
);
    localparam int AW = $clog2(MEM_WORDS);
    state_t state, next;
    logic [31:0] adr_q, dat_q, ram_q, mask;
    logic [3:0] sel_q;
    logic we_q, err_q, req, ok;
    logic [WAIT_W-1:0] cnt, wait_reg;
    logic [AW-1:0] ram_addr;
    function automatic logic [AW-1:0] idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction
    assign req = wb_cyc_i & wb_stb_i;
    assign ok = decode_ok(wb_adr_i, wb_sel_i, BASE_ADDR, 32'(MEM_WORDS * 4));
    assign busy_o = state != IDLE;
    assign wb_ack_o = state == RESP && !err_q;
    assign wb_err_o = state == RESP && err_q;
    assign mask = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
    assign wb_dat_o = (wb_ack_o && !we_q) ? ram_q & mask : 32'h0;
    // Read is issued one cycle ahead of RESP: from the live bus when W=0, else from the latched address.
    assign ram_addr = state == IDLE ? idx(wb_adr_i) : idx(adr_q);
    always_comb begin
        next = state;
        unique case (state)
            IDLE: next = req ? ((!ok || wait_reg == '0) ? RESP : WAIT) : IDLE;
            WAIT: next = !wb_cyc_i ? IDLE : (cnt == WAIT_W'(1) ? RESP : WAIT);
            RESP: next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            wait_reg <= RST_WAIT;
            cnt <= '0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= next;
            if (cfg_wait_we_i) wait_reg <= cfg_wait_i;
            if (state == IDLE && req) begin
                adr_q <= wb_adr_i;
                dat_q <= wb_dat_i;
                sel_q <= wb_sel_i;
                we_q <= wb_we_i;
                err_q <= !ok;
                cnt <= wait_reg;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
    eth_wb_mem_ram #(.WORDS(MEM_WORDS)) u_ram (
        .clk(wb_clk_i),
        .addr(ram_addr),
        .we((state == RESP && we_q && !err_q) ? sel_q : 4'b0000),
        .wdata(dat_q),
        .rdata(ram_q)
    );
`ifdef ETH_WB_SLAVE_MEM_STATS_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
            err_cnt_o <= '0;
        end else if (state == RESP) begin
            if (err_q && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
            if (!err_q && we_q && wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + 1'b1;
            if (!err_q && !we_q && rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_eth_wb_slave_mem.sv
// tb_eth_wb_slave_mem: directed bench for eth_wb_slave_mem (latency, byte enables, errors, abort, reset).
module tb_eth_wb_slave_mem;
    logic clk = 1'b0, rst = 1'b1;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat_i = '0, dat_o;
    logic [3:0] sel = '0, cfg_wait = '0;
    logic cfg_we = 1'b0, ack, err, busy;
`ifdef ETH_WB_SLAVE_MEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, err_cnt;
`endif
    int npass = 0, ntot = 0;
    int lat, bsy;
    logic t_ack, t_err;
    logic [31:0] rd;

    always #5 clk = ~clk;

    eth_wb_slave_mem dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_ack_o(ack), .wb_err_o(err), .cfg_wait_we_i(cfg_we), .cfg_wait_i(cfg_wait),
`ifdef ETH_WB_SLAVE_MEM_STATS_EN
        .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .err_cnt_o(err_cnt),
`endif
        .busy_o(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else npass++;
    endtask

    task automatic set_wait(input logic [3:0] v);
        @(posedge clk); #1 cfg_we = 1'b1; cfg_wait = v;
        @(posedge clk); #1 cfg_we = 1'b0;
    endtask

    // One classic cycle: returns edges-to-termination, busy cycles, which termination and read data.
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output int l, output int b, output logic ka, output logic ke, output logic [31:0] q);
        l = -1; b = 0; ka = 1'b0; ke = 1'b0; q = '0;
        @(posedge clk); #1 cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        for (int i = 1; i <= 40 && l < 0; i++) begin
            @(posedge clk); #1;
            if (busy) b++;
            if (ack || err) begin
                l = i; ka = ack; ke = err; q = dat_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("term_seen", 32'(l > 0), 32'd1);
        check("ack_err_excl", 32'(ka & ke), 32'd0);
        @(posedge clk); #1;
        check("term_pulse", {29'b0, ack, err, busy}, 32'd0);
    endtask

    initial begin
        #2;
        check("rst_outs", {dat_o[31:0] == 0 ? 29'b0 : 29'h1, ack, err, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, bsy, t_ack, t_err, rd);
        check("w10_lat", 32'(lat), 32'd2);
        check("w10_ack", {t_ack, t_err}, 32'b10);
        access(1'b0, 32'h10, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("r10_lat", 32'(lat), 32'd2);
        check("r10_data", rd, 32'hDEADBEEF);
        check("r10_ack", {t_ack, t_err}, 32'b10);

        set_wait(4'd0);
        access(1'b0, 32'h10, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("w0_lat", 32'(lat), 32'd1);
        check("w0_busy", 32'(bsy), 32'd1);
        set_wait(4'd15);
        access(1'b0, 32'h10, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("w15_lat", 32'(lat), 32'd16);
        check("w15_busy", 32'(bsy), 32'd16);
        check("w15_data", rd, 32'hDEADBEEF);

        set_wait(4'd0);
        access(1'b1, 32'h20, 4'hF, 32'h11223344, lat, bsy, t_ack, t_err, rd);
        access(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, lat, bsy, t_ack, t_err, rd);
        check("bsel_wr_ack", {t_ack, t_err}, 32'b10);
        access(1'b0, 32'h20, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("bsel_merge", rd, 32'h11BB33DD);
        access(1'b0, 32'h20, 4'b0011, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("rd_mask", rd, 32'h000033DD);

        access(1'b0, 32'h1002, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("err_1002", {t_ack, t_err}, 32'b01);
        access(1'b0, 32'h22, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("err_misalign", {t_ack, t_err}, 32'b01);
        access(1'b0, 32'h1000, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("err_top", {t_ack, t_err}, 32'b01);
        access(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, lat, bsy, t_ack, t_err, rd);
        check("err_sel0", {t_ack, t_err}, 32'b01);
        check("err_lat", 32'(lat), 32'd1);
        access(1'b0, 32'h20, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("err_nomem", rd, 32'h11BB33DD);
        access(1'b0, 32'hFFC, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("last_word_ok", {t_ack, t_err}, 32'b10);

        access(1'b1, 32'h30, 4'hF, 32'h01020304, lat, bsy, t_ack, t_err, rd);
        set_wait(4'd5);
        @(posedge clk); #1 cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30; sel = 4'hF; dat_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                seen = seen | ack | err;
            end
            check("abort_noterm", 32'(seen), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end
        access(1'b0, 32'h30, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("abort_nowrite", rd, 32'h01020304);
        check("w5_lat", 32'(lat), 32'd6);
`ifdef ETH_WB_SLAVE_MEM_STATS_EN
        check("rd_cnt", 32'(rd_cnt), 32'd8);
        check("wr_cnt", 32'(wr_cnt), 32'd4);
        check("err_cnt", 32'(err_cnt), 32'd4);
`endif

        access(1'b1, 32'h40, 4'hF, 32'h55AA55AA, lat, bsy, t_ack, t_err, rd);
        @(posedge clk); #1 cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; sel = 4'hF; dat_i = 32'h12345678;
        @(posedge clk);
        @(posedge clk); #3 rst = 1'b1;
        #1 check("async_rst", {29'b0, ack, err, busy}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
`ifdef ETH_WB_SLAVE_MEM_STATS_EN
        check("stats_rst", {rd_cnt, wr_cnt | err_cnt}, 32'd0);
`endif
        access(1'b0, 32'h40, 4'hF, 32'h0, lat, bsy, t_ack, t_err, rd);
        check("rst_nowrite", rd, 32'h55AA55AA);
        check("rst_wait_reg", 32'(lat), 32'd2);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
